// File: rtl/opl3_pkg.sv
// Shared types and constants for the OPL3 host-bus master.
// States R_* exist only when OPL3_BUS_STATUS_READ_EN is defined.
package opl3_pkg;

  localparam int REG_FILE_DATA_WIDTH = 8;

  localparam logic [3:0] ST_IDLE     = 4'd0;
  localparam logic [3:0] ST_A_SETUP  = 4'd1;
  localparam logic [3:0] ST_A_STROBE = 4'd2;
  localparam logic [3:0] ST_A_HOLD   = 4'd3;
  localparam logic [3:0] ST_A_REC    = 4'd4;
  localparam logic [3:0] ST_D_SETUP  = 4'd5;
  localparam logic [3:0] ST_D_STROBE = 4'd6;
  localparam logic [3:0] ST_D_HOLD   = 4'd7;
  localparam logic [3:0] ST_D_REC    = 4'd8;
  localparam logic [3:0] ST_R_SETUP  = 4'd9;
  localparam logic [3:0] ST_R_STROBE = 4'd10;
  localparam logic [3:0] ST_R_HOLD   = 4'd11;
  localparam logic [3:0] ST_R_REC    = 4'd12;

  typedef enum logic [3:0] {
    IDLE     = ST_IDLE,
    A_SETUP  = ST_A_SETUP,
    A_STROBE = ST_A_STROBE,
    A_HOLD   = ST_A_HOLD,
    A_REC    = ST_A_REC,
    D_SETUP  = ST_D_SETUP,
    D_STROBE = ST_D_STROBE,
    D_HOLD   = ST_D_HOLD,
    D_REC    = ST_D_REC
`ifdef OPL3_BUS_STATUS_READ_EN
    ,
    R_SETUP  = ST_R_SETUP,
    R_STROBE = ST_R_STROBE,
    R_HOLD   = ST_R_HOLD,
    R_REC    = ST_R_REC
`endif
  } bus_master_state_t;

  typedef struct packed {
    logic                           bank;
    logic [7:0]                     addr;
    logic [REG_FILE_DATA_WIDTH-1:0] data;
  } bus_write_req_t;

  function automatic int max4(int a, int b, int c, int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/host_bus_master_if.sv
// Request and OPL3 host-bus signals of host_bus_master.
// Status-read signals present only with OPL3_BUS_STATUS_READ_EN.
interface host_bus_master_if;

  logic                                     req_valid;
  logic                                     req_ready;
  logic                                     req_bank;
  logic [7:0]                               req_addr;
  logic [opl3_pkg::REG_FILE_DATA_WIDTH-1:0] req_data;
  logic                                     busy;
  logic                                     cs_n;
  logic                                     rd_n;
  logic                                     wr_n;
  logic [1:0]                               address;
  logic [opl3_pkg::REG_FILE_DATA_WIDTH-1:0] dout;
`ifdef OPL3_BUS_STATUS_READ_EN
  logic                                     rd_req;
  logic                                     rd_ack;
  logic [opl3_pkg::REG_FILE_DATA_WIDTH-1:0] din;
  logic [opl3_pkg::REG_FILE_DATA_WIDTH-1:0] status;
`endif

  modport master (
    input  req_valid, req_bank, req_addr, req_data,
    output req_ready, busy, cs_n, rd_n, wr_n, address, dout
`ifdef OPL3_BUS_STATUS_READ_EN
    ,
    input  rd_req, din,
    output rd_ack, status
`endif
  );

  modport slave (
    output req_valid, req_bank, req_addr, req_data,
    input  req_ready, busy, cs_n, rd_n, wr_n, address, dout
`ifdef OPL3_BUS_STATUS_READ_EN
    ,
    output rd_req, din,
    input  rd_ack, status
`endif
  );

endinterface

// File: rtl/bus_phase_timer.sv
// Loadable down-counter shared by every bus phase; done_o is high while the
// count is zero, so a load of N-1 gives an N-cycle state.
module bus_phase_timer #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             done_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = load_val_i;
    else if (cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/host_bus_master.sv
// OPL3 host-bus initiator: queued register writes become paced address/data bus cycles.
// Optional status read via `OPL3_BUS_STATUS_READ_EN (absent by default, rd_n tied high).
module host_bus_master
  import opl3_pkg::*;
#(
  parameter int SETUP_CYCLES   = 1,
  parameter int STROBE_CYCLES  = 4,
  parameter int HOLD_CYCLES    = 1,
  parameter int RECOVER_CYCLES = 16
) (
  input  logic         clk,
  input  logic         reset,
  host_bus_master_if.master bus
);

  localparam int MAX_CYCLES = max4(SETUP_CYCLES, STROBE_CYCLES, HOLD_CYCLES, RECOVER_CYCLES);
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam int W          = REG_FILE_DATA_WIDTH;

  bus_master_state_t state_q, state_d;
  bus_write_req_t    req_q, req_d;
  logic [8:0]        last_q;
  logic              last_vld_q;
  logic              run_q;
  logic              cs_n_q, wr_n_q;
  logic [1:0]        address_q;
  logic [W-1:0]      dout_q;
  logic              tmr_load, tmr_done;
  logic [CNT_W-1:0]  tmr_val;
  logic              accept, skip;

  function automatic logic [CNT_W-1:0] dur(bus_master_state_t s);
    case (s)
      A_SETUP, D_SETUP:   return CNT_W'(SETUP_CYCLES - 1);
      A_STROBE, D_STROBE: return CNT_W'(STROBE_CYCLES - 1);
      A_HOLD, D_HOLD:     return CNT_W'(HOLD_CYCLES - 1);
      A_REC, D_REC:       return CNT_W'(RECOVER_CYCLES - 1);
`ifdef OPL3_BUS_STATUS_READ_EN
      R_SETUP:            return CNT_W'(SETUP_CYCLES - 1);
      R_STROBE:           return CNT_W'(STROBE_CYCLES - 1);
      R_HOLD:             return CNT_W'(HOLD_CYCLES - 1);
      R_REC:              return CNT_W'(RECOVER_CYCLES - 1);
`endif
      default:            return '0;
    endcase
  endfunction

  // run_q keeps req_ready low while reset is asserted and for the first cycle after.
`ifdef OPL3_BUS_STATUS_READ_EN
  logic         rd_n_q;
  logic [W-1:0] status_q;
  logic         rd_go;

  assign rd_go         = run_q && (state_q == IDLE) && bus.rd_req;
  assign bus.req_ready = run_q && (state_q == IDLE) && !bus.rd_req;
  assign bus.rd_ack    = (state_q == R_REC) && tmr_done;
  assign bus.rd_n      = rd_n_q;
  assign bus.status    = status_q;
`else
  assign bus.req_ready = run_q && (state_q == IDLE);
  assign bus.rd_n      = 1'b1;
`endif

  assign accept = bus.req_valid && bus.req_ready;
  assign skip   = last_vld_q && (last_q == {bus.req_bank, bus.req_addr});

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    case (state_q)
      IDLE: begin
`ifdef OPL3_BUS_STATUS_READ_EN
        if (rd_go)
          state_d = R_SETUP;
        else
`endif
        if (accept) begin
          req_d   = '{bank: bus.req_bank, addr: bus.req_addr, data: bus.req_data};
          state_d = skip ? D_SETUP : A_SETUP;
        end
      end
      A_SETUP:  if (tmr_done) state_d = A_STROBE;
      A_STROBE: if (tmr_done) state_d = A_HOLD;
      A_HOLD:   if (tmr_done) state_d = A_REC;
      A_REC:    if (tmr_done) state_d = D_SETUP;
      D_SETUP:  if (tmr_done) state_d = D_STROBE;
      D_STROBE: if (tmr_done) state_d = D_HOLD;
      D_HOLD:   if (tmr_done) state_d = D_REC;
      D_REC:    if (tmr_done) state_d = IDLE;
`ifdef OPL3_BUS_STATUS_READ_EN
      R_SETUP:  if (tmr_done) state_d = R_STROBE;
      R_STROBE: if (tmr_done) state_d = R_HOLD;
      R_HOLD:   if (tmr_done) state_d = R_REC;
      R_REC:    if (tmr_done) state_d = IDLE;
`endif
      default:  state_d = IDLE;
    endcase
  end

  assign tmr_load = (state_d != state_q);
  assign tmr_val  = dur(state_d);

  bus_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk       (clk),
    .reset     (reset),
    .load_i    (tmr_load),
    .load_val_i(tmr_val),
    .done_o    (tmr_done)
  );

  // Bus pins are registered from the next state so they line up with state_q glitch-free.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      run_q      <= 1'b0;
      last_vld_q <= 1'b0;
      cs_n_q     <= 1'b1;
      wr_n_q     <= 1'b1;
      address_q  <= 2'b00;
      dout_q     <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
      if ((state_q == A_REC) && tmr_done)
        last_vld_q <= 1'b1;
      cs_n_q <= !(state_d inside {A_STROBE, D_STROBE
`ifdef OPL3_BUS_STATUS_READ_EN
                                  , R_STROBE
`endif
                                  });
      wr_n_q <= !(state_d inside {A_SETUP, A_STROBE, A_HOLD, D_SETUP, D_STROBE, D_HOLD});
      case (state_d)
        A_SETUP, A_STROBE, A_HOLD: begin
          address_q <= {req_d.bank, 1'b0};
          dout_q    <= req_d.addr;
        end
        D_SETUP, D_STROBE, D_HOLD: begin
          address_q <= {req_d.bank, 1'b1};
          dout_q    <= req_d.data;
        end
`ifdef OPL3_BUS_STATUS_READ_EN
        R_SETUP, R_STROBE, R_HOLD: address_q <= 2'b00;
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    req_q <= req_d;
    if ((state_q == A_REC) && tmr_done)
      last_q <= {req_q.bank, req_q.addr};
  end

`ifdef OPL3_BUS_STATUS_READ_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_n_q   <= 1'b1;
      status_q <= '0;
    end else begin
      rd_n_q <= !(state_d inside {R_SETUP, R_STROBE, R_HOLD});
      if ((state_q == R_STROBE) && tmr_done)
        status_q <= bus.din;
    end
  end
`endif

  assign bus.busy    = (state_q != IDLE);
  assign bus.cs_n    = cs_n_q;
  assign bus.wr_n    = wr_n_q;
  assign bus.address = address_q;
  assign bus.dout    = dout_q;

endmodule

// File: tb/tb_host_bus_master.sv
// Directed bench for host_bus_master: default-timing DUT (ifa) and a
// minimum-timing DUT (ifb, STROBE=3, others 1).
module tb_host_bus_master;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  host_bus_master_if ifa ();
  host_bus_master_if ifb ();

  host_bus_master u_dut_a (.clk(clk), .reset(reset), .bus(ifa));
  host_bus_master #(.SETUP_CYCLES(1), .STROBE_CYCLES(3), .HOLD_CYCLES(1), .RECOVER_CYCLES(1))
    u_dut_b (.clk(clk), .reset(reset), .bus(ifb));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Selected-DUT view for the shared tasks
  logic       sel = 1'b0;
  logic       m_cs_n, m_wr_n, m_ready, m_busy;
  logic [1:0] m_addr;
  logic [7:0] m_dout;
  always_comb begin
    m_cs_n = sel ? ifb.cs_n : ifa.cs_n;
    m_wr_n = sel ? ifb.wr_n : ifa.wr_n;
    m_ready = sel ? ifb.req_ready : ifa.req_ready;
    m_busy = sel ? ifb.busy : ifa.busy;
    m_addr = sel ? ifb.address : ifa.address;
    m_dout = sel ? ifb.dout : ifa.dout;
  end

  // Bus protocol watchdogs, active outside reset
  int viol_a = 0, viol_b = 0;
  logic pa_cs = 1'b1, pb_cs = 1'b1, p_rst = 1'b0;
  logic [1:0] pa_addr = '0, pb_addr = '0;
  logic [7:0] pa_dout = '0, pb_dout = '0;
  always @(negedge clk) begin
    if (!reset && !p_rst) begin
      if (!ifa.wr_n && !ifa.rd_n) viol_a <= viol_a + 1;
      if (!ifb.wr_n && !ifb.rd_n) viol_b <= viol_b + 1;
      if (pa_cs && !ifa.cs_n && (pa_addr != ifa.address || pa_dout != ifa.dout)) viol_a <= viol_a + 1;
      if (pb_cs && !ifb.cs_n && (pb_addr != ifb.address || pb_dout != ifb.dout)) viol_b <= viol_b + 1;
    end
    p_rst <= reset;
    pa_cs <= ifa.cs_n; pa_addr <= ifa.address; pa_dout <= ifa.dout;
    pb_cs <= ifb.cs_n; pb_addr <= ifb.address; pb_dout <= ifb.dout;
  end

  task automatic drive(input logic s, input logic v, input logic b, input logic [7:0] a, input logic [7:0] d);
    if (s) begin
      ifb.req_valid = v; ifb.req_bank = b; ifb.req_addr = a; ifb.req_data = d;
    end else begin
      ifa.req_valid = v; ifa.req_bank = b; ifa.req_addr = a; ifa.req_data = d;
    end
  endtask

  task automatic start_req(input logic s, input logic b, input logic [7:0] a, input logic [7:0] d);
    bit ok;
    sel = s;
    ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (m_ready) ok = 1;
    end
    chk("ready_wait", int'(ok), 1);
    drive(s, 1'b1, b, a, d);
    @(posedge clk);
    #1 drive(s, 1'b0, b, a, d);
  endtask

  int r_len, r_pulses, r_w0, r_w1, r_wrlow, r_busydrop;
  logic [1:0] r_a0, r_a1;
  logic [7:0] r_d0, r_d1;
  bit r_done;

  task automatic run_req(input logic s, input logic b, input logic [7:0] a, input logic [7:0] d);
    logic pcs;
    start_req(s, b, a, d);
    r_len = 0; r_pulses = 0; r_w0 = 0; r_w1 = 0; r_wrlow = 0; r_busydrop = 0; r_done = 0;
    r_a0 = '0; r_a1 = '0; r_d0 = '0; r_d1 = '0;
    pcs = 1'b1;
    while (!r_done && r_len < 300) begin
      @(negedge clk);
      r_len++;
      if (m_ready) r_done = 1;
      else begin
        if (!m_busy) r_busydrop++;
        if (!m_wr_n) r_wrlow++;
        if (!m_cs_n) begin
          if (pcs) begin
            r_pulses++;
            if (r_pulses == 1) begin r_a0 = m_addr; r_d0 = m_dout; end
            else begin r_a1 = m_addr; r_d1 = m_dout; end
          end
          if (r_pulses == 1) r_w0++; else r_w1++;
        end
        pcs = m_cs_n;
      end
    end
    chk("req_done", int'(r_done), 1);
  endtask

  typedef struct {
    logic s; logic b; logic [7:0] a; logic [7:0] d;
    int pulses; logic [1:0] a0; logic [7:0] d0; logic [1:0] a1; logic [7:0] d1;
    int csw; int wrlow; int len;
  } vec_t;
  vec_t vecs[9];

  int hs, pulses4;
  logic pend, pcs4;
  logic [7:0] q_a[3];
  logic [7:0] q_d[3];
  logic       q_b[3];
  int idx;
  bit found;

  initial begin
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
`ifdef OPL3_BUS_STATUS_READ_EN
    ifa.rd_req = 1'b0; ifa.din = 8'h00;
    ifb.rd_req = 1'b0; ifb.din = 8'h00;
`endif
    //             s     b     addr   data  p  a0     d0     a1     d1     csw wrl len
    vecs[0] = '{1'b0, 1'b0, 8'h20, 8'h01, 2, 2'b00, 8'h20, 2'b01, 8'h01, 4, 12, 45};
    vecs[1] = '{1'b0, 1'b1, 8'hB0, 8'h11, 2, 2'b10, 8'hB0, 2'b11, 8'h11, 4, 12, 45};
    vecs[2] = '{1'b0, 1'b1, 8'hB0, 8'h22, 1, 2'b11, 8'h22, 2'b00, 8'h00, 4, 6, 23};
    vecs[3] = '{1'b0, 1'b0, 8'h20, 8'h33, 2, 2'b00, 8'h20, 2'b01, 8'h33, 4, 12, 45};
    vecs[4] = '{1'b0, 1'b0, 8'h20, 8'h44, 1, 2'b01, 8'h44, 2'b00, 8'h00, 4, 6, 23};
    vecs[5] = '{1'b0, 1'b1, 8'h20, 8'h55, 2, 2'b10, 8'h20, 2'b11, 8'h55, 4, 12, 45};
    vecs[6] = '{1'b1, 1'b0, 8'h05, 8'hA5, 2, 2'b00, 8'h05, 2'b01, 8'hA5, 3, 10, 13};
    vecs[7] = '{1'b1, 1'b0, 8'h05, 8'h5A, 1, 2'b01, 8'h5A, 2'b00, 8'h00, 3, 5, 7};
    vecs[8] = '{1'b1, 1'b1, 8'hFF, 8'h00, 2, 2'b10, 8'hFF, 2'b11, 8'h00, 3, 10, 13};

    // Reset values
    #1 reset = 1'b1;
    #1;
    chk("rst_cs_n", int'(ifa.cs_n), 1);
    chk("rst_wr_n", int'(ifa.wr_n), 1);
    chk("rst_rd_n", int'(ifa.rd_n), 1);
    chk("rst_address", int'(ifa.address), 0);
    chk("rst_dout", int'(ifa.dout), 0);
    chk("rst_req_ready", int'(ifa.req_ready), 0);
    chk("rst_busy", int'(ifa.busy), 0);
    chk("rst_b_ready", int'(ifb.req_ready), 0);
`ifdef OPL3_BUS_STATUS_READ_EN
    chk("rst_status", int'(ifa.status), 0);
    chk("rst_rd_ack", int'(ifa.rd_ack), 0);
`endif
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Table: full cycles, address skips, bank change, minimum timing
    for (int i = 0; i < 9; i++) begin
      run_req(vecs[i].s, vecs[i].b, vecs[i].a, vecs[i].d);
      chk($sformatf("v%0d_pulses", i), r_pulses, vecs[i].pulses);
      chk($sformatf("v%0d_addr0", i), int'(r_a0), int'(vecs[i].a0));
      chk($sformatf("v%0d_dout0", i), int'(r_d0), int'(vecs[i].d0));
      chk($sformatf("v%0d_csw0", i), r_w0, vecs[i].csw);
      if (vecs[i].pulses == 2) begin
        chk($sformatf("v%0d_addr1", i), int'(r_a1), int'(vecs[i].a1));
        chk($sformatf("v%0d_dout1", i), int'(r_d1), int'(vecs[i].d1));
        chk($sformatf("v%0d_csw1", i), r_w1, vecs[i].csw);
      end
      chk($sformatf("v%0d_wr_low", i), r_wrlow, vecs[i].wrlow);
      chk($sformatf("v%0d_len", i), r_len, vecs[i].len);
      chk($sformatf("v%0d_busy_drop", i), r_busydrop, 0);
    end

    // Reset during D_STROBE of a skipped-address request
    start_req(1'b0, 1'b1, 8'h20, 8'h66);
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (!m_cs_n) found = 1;
    end
    chk("t3_strobe_seen", int'(found), 1);
    chk("t3_skip_addr", int'(m_addr), 3);
    #2 reset = 1'b1;
    #1;
    chk("t3_cs_n_async", int'(ifa.cs_n), 1);
    chk("t3_wr_n_async", int'(ifa.wr_n), 1);
    chk("t3_busy_async", int'(ifa.busy), 0);
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    run_req(1'b0, 1'b1, 8'h20, 8'h99);
    chk("t3_pulses", r_pulses, 2);
    chk("t3_addr0", int'(r_a0), 2);
    chk("t3_dout0", int'(r_d0), 8'h20);
    chk("t3_dout1", int'(r_d1), 8'h99);
    chk("t3_len", r_len, 45);

    // req_valid held high across three queued requests (full, skip, full)
    q_b[0] = 1'b0; q_a[0] = 8'h40; q_d[0] = 8'h01;
    q_b[1] = 1'b0; q_a[1] = 8'h40; q_d[1] = 8'h02;
    q_b[2] = 1'b1; q_a[2] = 8'h41; q_d[2] = 8'h03;
    sel = 1'b0; idx = 0; hs = 0; pend = 0; pulses4 = 0; pcs4 = 1'b1;
    @(negedge clk);
    drive(1'b0, 1'b1, q_b[0], q_a[0], q_d[0]);
    for (int c = 0; c < 170; c++) begin
      if (ifa.req_valid && m_ready) begin hs++; pend = 1; end
      @(posedge clk);
      #1;
      if (pend) begin
        pend = 0;
        idx++;
        if (idx < 3) drive(1'b0, 1'b1, q_b[idx], q_a[idx], q_d[idx]);
        else drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      end
      @(negedge clk);
      if (!m_cs_n && pcs4) pulses4++;
      pcs4 = m_cs_n;
    end
    chk("t4_handshakes", hs, 3);
    chk("t4_cs_pulses", pulses4, 5);
    chk("t4_idle_after", int'(ifa.busy), 0);

`ifdef OPL3_BUS_STATUS_READ_EN
    // Status read wins over a simultaneous write request
    begin
      int acks;
      bit seen, read_first, hs_after;
      acks = 0; seen = 0; read_first = 0; hs_after = 0; hs = 0; pend = 0;
      sel = 1'b0;
      @(negedge clk);
      ifa.din = 8'h60;
      ifa.rd_req = 1'b1;
      drive(1'b0, 1'b1, 1'b0, 8'h12, 8'h34);
      for (int c = 0; c < 150; c++) begin
        if (!m_cs_n && !seen) begin
          seen = 1;
          read_first = !ifa.rd_n && ifa.wr_n && (ifa.address == 2'b00);
        end
        if (ifa.rd_ack) begin acks++; ifa.rd_req = 1'b0; end
        if (ifa.req_valid && m_ready) begin hs++; hs_after = (acks > 0); pend = 1; end
        @(posedge clk);
        #1;
        if (pend) begin pend = 0; drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00); end
        @(negedge clk);
      end
      chk("t5_read_first", int'(read_first), 1);
      chk("t5_rd_ack_pulses", acks, 1);
      chk("t5_status", int'(ifa.status), 8'h60);
      chk("t5_write_handshake", hs, 1);
      chk("t5_write_after_read", int'(hs_after), 1);
    end
`endif

    @(negedge clk);
    chk("proto_a", viol_a, 0);
    chk("proto_b", viol_b, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
